// File: rtl/xmtfifo.sv
// xmtfifo: serial-line transmitter fed by a circular transmit FIFO.
// Characters are framed as start, DATA_BITS (LSB first), optional parity and
// STOP_BITS stop bits, each bit lasting BAUD_DIV clock cycles.
module xmtfifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int BAUD_DIV   = 434,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 write,
    output logic                 ready,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 flush,
    output logic [CNT_W-1:0]     level,
    output logic                 idle,
    output logic                 serial_out
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int NW = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CNT_W-1:0]     level_nxt;
    logic                 push;
    logic                 pop;
    logic                 baud_last;
    logic                 frame_done;
    logic                 to_idle;

    state_t               state;
    logic [BW-1:0]        baud_cnt;
    logic [NW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bit;
    logic [DATA_BITS-1:0] head;

    assign head = mem[rd_ptr];

    // Handshake decode: pop when the engine can take a character, next level
    always_comb begin
        baud_last  = (baud_cnt == BW'(BAUD_DIV - 1));
        frame_done = (state == ST_STOP) && baud_last && (bit_cnt == NW'(STOP_BITS - 1));
        pop        = (level != '0) && ((state == ST_IDLE) || frame_done);
        push       = write && ready && !flush;
        to_idle    = !pop && ((state == ST_IDLE) || frame_done);
        level_nxt  = level;
        if (flush)
            level_nxt = '0;
        else if (push && !pop)
            level_nxt = level + CNT_W'(1);
        else if (!push && pop)
            level_nxt = level - CNT_W'(1);
    end

    // FIFO pointers, occupancy and registered ready
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ready  <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (flush)
                rd_ptr <= wr_ptr;
            else if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            level <= level_nxt;
            ready <= (level_nxt != CNT_W'(FIFO_DEPTH));
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= data_in;
    end

    // Shift engine: frame sequencing, bit timing and registered line/idle
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            serial_out <= 1'b1;
            idle       <= 1'b1;
        end else begin
            idle <= to_idle && (level_nxt == '0);
            if (state != ST_IDLE)
                baud_cnt <= baud_last ? '0 : baud_cnt + BW'(1);
            // Pop from IDLE or straight out of the last stop cycle: no gap
            if (pop) begin
                state      <= ST_START;
                baud_cnt   <= '0;
                bit_cnt    <= '0;
                shift      <= head;
                par_bit    <= (^head) ^ (PARITY == 2);
                serial_out <= 1'b0;
            end else begin
                case (state)
                    ST_START: if (baud_last) begin
                        state      <= ST_DATA;
                        bit_cnt    <= '0;
                        serial_out <= shift[0];
                    end
                    ST_DATA: if (baud_last) begin
                        if (bit_cnt == NW'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
                            if (PARITY != 0) begin
                                state      <= ST_PAR;
                                serial_out <= par_bit;
                            end else begin
                                state      <= ST_STOP;
                                serial_out <= 1'b1;
                            end
                        end else begin
                            bit_cnt    <= bit_cnt + NW'(1);
                            serial_out <= shift[1];
                            shift      <= {1'b0, shift[DATA_BITS-1:1]};
                        end
                    end
                    ST_PAR: if (baud_last) begin
                        state      <= ST_STOP;
                        bit_cnt    <= '0;
                        serial_out <= 1'b1;
                    end
                    ST_STOP: if (baud_last) begin
                        if (frame_done) begin
                            state      <= ST_IDLE;
                            bit_cnt    <= '0;
                            serial_out <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + NW'(1);
                        end
                    end
                    default: begin
                        state      <= ST_IDLE;
                        serial_out <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/xmtfifo.md
Name: xmtfifo

Overview:
- Parametrised serial-line transmitter with an integrated transmit FIFO.
- The CPU-side bus interface writes characters into a FIFO of configurable depth. An internal shift engine frames and sends them with configurable data width, parity and stop bits at a bit rate set by a clock divisor.
- Replaces the single-holding-register transmit buffer, so software can queue bursts without polling per character.

Parameters:
DATA_BITS, 8, character width in bits (5..8)
FIFO_DEPTH, 16, FIFO entries; power of two, 2..256
BAUD_DIV, 434, clk cycles per serial bit (>= 2)
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, number of stop bits (1 or 2)
CNT_W, clog2(FIFO_DEPTH+1), width of the level output

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous reset, active-low (reset == 0 resets)
write  input  1  write strobe, one character per cycle
ready  output  1  FIFO not full; write is accepted only when write && ready
data_in  input  DATA_BITS  character to enqueue
flush  input  1  discard all queued (not yet started) characters
level  output  CNT_W  number of characters in the FIFO, excluding the one being shifted
idle  output  1  FIFO empty and no frame in progress
serial_out  output  1  serial line, idle high

Behaviour:
- Reset (reset == 0 at an edge), including mid-frame:
  - After that edge: FIFO empty, level = 0, ready = 1, idle = 1, serial_out = 1, engine in IDLE, baud and bit counters = 0.
  - An aborted frame is not completed.
- FIFO:
  - Circular buffer with read/write pointers and a registered occupancy counter.
  - All outputs are registered.
  - ready = (level != FIFO_DEPTH).
  - A write while full is ignored; no overwrite and no error flag.
- Enqueue: write && ready at edge N stores data_in. At edge N, level increments (unless a pop happens in the same cycle) and ready updates.
- Simultaneous push and pop:
  - level is unchanged.
  - When full, ready = 0 for that cycle, so the write is rejected even though a pop occurs. No write-through-when-full.
- Flush:
  - At the edge where flush = 1: level = 0 and pointers are equalised.
  - A concurrent write is discarded; flush has priority.
  - A frame already in progress completes normally.
- Engine states: IDLE, START, DATA, PAR, STOP.
  - IDLE: if the FIFO is non-empty, pop the head into the shift register, go to START, drive serial_out = 0. A character written at edge N from full idle drives serial_out low after edge N+1.
  - START: 1 bit time, serial_out = 0.
  - DATA: DATA_BITS bit times, LSB first.
  - PAR: 1 bit time, only if PARITY != 0. Even parity = XOR of data bits; odd parity = its inverse.
  - STOP: STOP_BITS bit times, serial_out = 1.
- Bit timing:
  - Each bit time is exactly BAUD_DIV cycles, counted by a 0..BAUD_DIV-1 counter that restarts at every bit.
  - Frame length = (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * BAUD_DIV cycles.
- Back-to-back frames:
  - At the last cycle of the final STOP bit, if the FIFO is non-empty, the engine pops and enters START directly. No idle gap.
  - Otherwise it returns to IDLE.
- idle = 1 only in IDLE state with level = 0. It is deasserted the edge after a write into an empty idle block.
- Unused data_in bits beyond DATA_BITS do not exist; the port width tracks DATA_BITS.
- Pointer wrap: pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Full/empty is determined from level, not from pointer comparison.

Test Plan:
- Reset with 8N1 and BAUD_DIV=4: after reset, serial_out=1, ready=1, level=0, idle=1. Write 0x55; serial_out goes low 2 edges later, then the sequence 0,1,0,1,0,1,0,1,0,1 (start, LSB first, stop), each held 4 cycles; idle=1 after 40 cycles.
- Burst fill with FIFO_DEPTH=4 and BAUD_DIV=4: write 6 characters on consecutive cycles.
  - The first is popped, so 4 queue and ready=0 after the 5th accepted write; the 6th is dropped.
  - Frames on the line are exactly 0x01..0x05, with no gap between stop and next start.
- Parity and stop variants:
  - DATA_BITS=7, PARITY=1, STOP_BITS=2: sending 0x07 yields parity bit 1 and a 2-bit stop; frame length 11*BAUD_DIV.
  - With PARITY=2, the same character yields parity bit 0.
- Flush: queue 3 characters behind an active frame, assert flush mid-frame together with write. The current frame completes, level=0 on the next edge, the concurrent write is discarded, and no further frames are sent.
- Reset mid-frame: drive reset=0 during DATA bit 3 with 2 characters queued. serial_out=1 after that edge, level=0, idle=1, and no remaining bits are emitted.
- Full with simultaneous pop: with the FIFO full, assert write on the cycle the engine pops. The write is rejected, level = FIFO_DEPTH-1 afterwards, and ready=1 on the following cycle.
